la_axis_egress_arb: RTL and testbench

//   Packet-level AXI-Stream arbiter sharing the single upstream AXIS egress port between the

---
 rtl/la_arb_pkg.sv | 13 +
 rtl/la_arb_decide.sv | 39 +++
 rtl/la_axis_egress_arb.sv | 143 ++++++++++++++
 tb/tb_la_axis_egress_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_arb_pkg.sv
// Shared state encodings and source tags for the AXIS egress arbiter.
package la_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GNT_UP = 2'd1,
      ST_GNT_LA = 2'd2
   } arb_state_t;

   localparam logic TID_UP = 1'b0;
   localparam logic TID_LA = 1'b1;

endpackage

// File: rtl/la_arb_decide.sv
// Combinational grant decision: LA high priority first, then round-robin
// against the last granted source, then whichever single source is valid.
module la_arb_decide
   import la_arb_pkg::*;
(
   input  logic enable,
   input  logic up_valid,
   input  logic la_valid,
   input  logic la_hpri,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_src,
   output logic hpri_win
);

   // Pick the next grant; nothing is granted while disabled.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_src   = TID_UP;
      hpri_win  = 1'b0;
      if (enable) begin
         if (la_hpri && la_valid) begin
            gnt_valid = 1'b1;
            gnt_src   = TID_LA;
            hpri_win  = 1'b1;
         end else if (up_valid && la_valid) begin
            gnt_valid = 1'b1;
            gnt_src   = (last_gnt == TID_UP) ? TID_LA : TID_UP;
         end else if (up_valid) begin
            gnt_valid = 1'b1;
            gnt_src   = TID_UP;
         end else if (la_valid) begin
            gnt_valid = 1'b1;
            gnt_src   = TID_LA;
         end
      end
   end

endmodule

// File: rtl/la_axis_egress_arb.sv
// Packet-level arbiter sharing one AXIS egress port between the user project
// (UP) stream and the logic-analyzer (LA) trace stream.
module la_axis_egress_arb
   import la_arb_pkg::*;
#(
   parameter int pDATA_WIDTH = 32,
   parameter int pLA_IDLE_TO = 16,
   parameter int pCNT_WIDTH  = 16
) (
   input  logic                     axis_clk,
   input  logic                     axis_rst_n,
   input  logic [pDATA_WIDTH-1:0]   up_tdata,
   input  logic [pDATA_WIDTH/8-1:0] up_tstrb,
   input  logic [pDATA_WIDTH/8-1:0] up_tkeep,
   input  logic                     up_tlast,
   input  logic                     up_tvalid,
   input  logic [1:0]               up_tuser,
   output logic                     up_tready,
   input  logic [pDATA_WIDTH-1:0]   la_tdata,
   input  logic [pDATA_WIDTH/8-1:0] la_tstrb,
   input  logic [pDATA_WIDTH/8-1:0] la_tkeep,
   input  logic                     la_tlast,
   input  logic                     la_tvalid,
   input  logic [1:0]               la_tuser,
   output logic                     la_tready,
   input  logic                     la_hpri_req,
   output logic [pDATA_WIDTH-1:0]   m_tdata,
   output logic [pDATA_WIDTH/8-1:0] m_tstrb,
   output logic [pDATA_WIDTH/8-1:0] m_tkeep,
   output logic                     m_tlast,
   output logic                     m_tvalid,
   output logic [1:0]               m_tuser,
   output logic                     m_tid,
   input  logic                     m_tready,
   input  logic                     arb_enable,
   output logic                     la_idle_rel,
   output logic [pCNT_WIDTH-1:0]    hpri_gnt_cnt
);

   localparam int IDLE_W = (pLA_IDLE_TO > 1) ? $clog2(pLA_IDLE_TO) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(pLA_IDLE_TO - 1);

   arb_state_t        state, state_nxt;
   logic              last_gnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              eop, idle_rel, reeval, load;
   logic              gnt_valid, gnt_src, hpri_win;

   la_arb_decide u_decide (
      .enable    (arb_enable),
      .up_valid  (up_tvalid),
      .la_valid  (la_tvalid),
      .la_hpri   (la_hpri_req),
      .last_gnt  (last_gnt),
      .gnt_valid (gnt_valid),
      .gnt_src   (gnt_src),
      .hpri_win  (hpri_win)
   );

   // Release points (end of packet, LA idle timeout) re-run the decision in
   // the same cycle so back-to-back packets see no bubble.
   always_comb begin
      eop       = 1'b0;
      idle_rel  = 1'b0;
      state_nxt = state;
      case (state)
         ST_GNT_UP: eop = up_tvalid && up_tlast && m_tready;
         ST_GNT_LA: begin
            eop      = la_tvalid && la_tlast && m_tready;
            idle_rel = !la_tvalid && (idle_cnt == IDLE_LAST);
         end
         default: ;
      endcase
      reeval = (state == ST_IDLE) || eop || idle_rel;
      load   = reeval && gnt_valid;
      if (reeval) begin
         if (!gnt_valid)
            state_nxt = ST_IDLE;
         else if (gnt_src == TID_LA)
            state_nxt = ST_GNT_LA;
         else
            state_nxt = ST_GNT_UP;
      end
   end

   // State, last grant, LA idle counter and saturating hpri statistic.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state        <= ST_IDLE;
         last_gnt     <= TID_LA;
         idle_cnt     <= '0;
         hpri_gnt_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load)
            last_gnt <= gnt_src;
         if (load && hpri_win && (hpri_gnt_cnt != '1))
            hpri_gnt_cnt <= hpri_gnt_cnt + 1'b1;
         if (state != ST_GNT_LA || la_tvalid || idle_rel)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Egress data mux and ready steering driven by the current grant.
   always_comb begin
      m_tdata     = '0;
      m_tstrb     = '0;
      m_tkeep     = '0;
      m_tlast     = 1'b0;
      m_tvalid    = 1'b0;
      m_tuser     = '0;
      m_tid       = TID_UP;
      up_tready   = 1'b0;
      la_tready   = 1'b0;
      la_idle_rel = idle_rel;
      case (state)
         ST_GNT_UP: begin
            m_tdata   = up_tdata;
            m_tstrb   = up_tstrb;
            m_tkeep   = up_tkeep;
            m_tlast   = up_tlast;
            m_tvalid  = up_tvalid;
            m_tuser   = up_tuser;
            m_tid     = TID_UP;
            up_tready = m_tready;
         end
         ST_GNT_LA: begin
            m_tdata   = la_tdata;
            m_tstrb   = la_tstrb;
            m_tkeep   = la_tkeep;
            m_tlast   = la_tlast;
            m_tvalid  = la_tvalid;
            m_tuser   = la_tuser;
            m_tid     = TID_LA;
            la_tready = m_tready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_la_axis_egress_arb.sv
// Directed self-checking bench for la_axis_egress_arb.
module tb_la_axis_egress_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] up_tdata, la_tdata, m_tdata;
   logic [3:0]  up_tstrb, up_tkeep, la_tstrb, la_tkeep, m_tstrb, m_tkeep;
   logic        up_tlast, up_tvalid, up_tready;
   logic        la_tlast, la_tvalid, la_tready;
   logic [1:0]  up_tuser, la_tuser, m_tuser;
   logic        la_hpri_req, m_tlast, m_tvalid, m_tid, m_tready, arb_enable;
   logic        la_idle_rel;
   logic [15:0] hpri_gnt_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   int up_idx, la_idx, exp_up, exp_la;
   bit pkt_open;
   logic cur_tid;
   logic up_fire, la_fire;

   la_axis_egress_arb #(
      .pDATA_WIDTH (32),
      .pLA_IDLE_TO (16),
      .pCNT_WIDTH  (16)
   ) dut (
      .axis_clk     (clk),
      .axis_rst_n   (rst_n),
      .up_tdata     (up_tdata),
      .up_tstrb     (up_tstrb),
      .up_tkeep     (up_tkeep),
      .up_tlast     (up_tlast),
      .up_tvalid    (up_tvalid),
      .up_tuser     (up_tuser),
      .up_tready    (up_tready),
      .la_tdata     (la_tdata),
      .la_tstrb     (la_tstrb),
      .la_tkeep     (la_tkeep),
      .la_tlast     (la_tlast),
      .la_tvalid    (la_tvalid),
      .la_tuser     (la_tuser),
      .la_tready    (la_tready),
      .la_hpri_req  (la_hpri_req),
      .m_tdata      (m_tdata),
      .m_tstrb      (m_tstrb),
      .m_tkeep      (m_tkeep),
      .m_tlast      (m_tlast),
      .m_tvalid     (m_tvalid),
      .m_tuser      (m_tuser),
      .m_tid        (m_tid),
      .m_tready     (m_tready),
      .arb_enable   (arb_enable),
      .la_idle_rel  (la_idle_rel),
      .hpri_gnt_cnt (hpri_gnt_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      up_tdata    = '0; up_tstrb = '0; up_tkeep = '0; up_tlast = 1'b0;
      up_tvalid   = 1'b0; up_tuser = '0;
      la_tdata    = '0; la_tstrb = '0; la_tkeep = '0; la_tlast = 1'b0;
      la_tvalid   = 1'b0; la_tuser = '0;
      la_hpri_req = 1'b0;
      m_tready    = 1'b1;
      arb_enable  = 1'b1;
      next_cycle();
      next_cycle();
      chk("rst_m_tvalid",  32'(m_tvalid), 32'(0));
      chk("rst_m_tdata",   m_tdata, 32'(0));
      chk("rst_m_tlast",   32'(m_tlast), 32'(0));
      chk("rst_m_tuser",   32'(m_tuser), 32'(0));
      chk("rst_m_tid",     32'(m_tid), 32'(0));
      chk("rst_up_tready", 32'(up_tready), 32'(0));
      chk("rst_la_tready", 32'(la_tready), 32'(0));
      chk("rst_idle_rel",  32'(la_idle_rel), 32'(0));
      chk("rst_hpri_cnt",  32'(hpri_gnt_cnt), 32'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      // ---- 1: UP alone, 3-beat packet ----
      do_reset();
      up_tstrb = 4'hF; up_tkeep = 4'h7; up_tuser = 2'b10;
      up_tvalid = 1'b1; up_idx = 0;
      for (int k = 0; k < 5; k++) begin
         up_tvalid = (up_idx < 3);
         up_tdata  = 32'h1000_0000 + 32'(up_idx);
         up_tlast  = (up_idx == 2);
         @(negedge clk);
         if (k == 0) begin
            chk("t1_lat_valid",  32'(m_tvalid), 32'(0));
            chk("t1_lat_tready", 32'(up_tready), 32'(0));
         end else if (k <= 3) begin
            chk("t1_valid", 32'(m_tvalid), 32'(1));
            chk("t1_tid",   32'(m_tid), 32'(0));
            chk("t1_data",  m_tdata, 32'h1000_0000 + 32'(k - 1));
            chk("t1_last",  32'(m_tlast), 32'(k == 3));
            chk("t1_ready", 32'(up_tready), 32'(1));
            chk("t1_sideband", {22'd0, m_tuser, m_tkeep, m_tstrb}, 32'h0000_027F);
         end else begin
            chk("t1_done_valid", 32'(m_tvalid), 32'(0));
         end
         up_fire = up_tvalid && up_tready;
         next_cycle();
         if (up_fire) up_idx++;
      end

      // ---- 2: both streaming 2-beat packets, round-robin, no bubble ----
      do_reset();
      up_idx = 0; la_idx = 0;
      up_tvalid = 1'b1; la_tvalid = 1'b1;
      for (int k = 0; k < 11; k++) begin
         up_tdata = 32'hA000_0000 + 32'(up_idx); up_tlast = up_idx[0];
         la_tdata = 32'hB000_0000 + 32'(la_idx); la_tlast = la_idx[0];
         @(negedge clk);
         if (k == 0) begin
            chk("t2_first_idle", 32'(m_tvalid), 32'(0));
         end else begin
            chk("t2_valid", 32'(m_tvalid), 32'(1));
            chk("t2_tid",   32'(m_tid), 32'(((k - 1) / 2) % 2));
            chk("t2_data",  m_tdata,
                (((k - 1) / 2) % 2 == 0 ? 32'hA000_0000 : 32'hB000_0000)
                + 32'((((k - 1) / 4) * 2) + ((k - 1) % 2)));
         end
         up_fire = up_tvalid && up_tready;
         la_fire = la_tvalid && la_tready;
         next_cycle();
         if (up_fire) up_idx++;
         if (la_fire) la_idx++;
      end

      // ---- 3: hpri raised during an 8-beat UP packet ----
      do_reset();
      up_idx = 0; la_idx = 0;
      for (int k = 0; k < 12; k++) begin
         up_tvalid   = (up_idx < 8);
         up_tdata    = 32'hC000_0000 + 32'(up_idx);
         up_tlast    = (up_idx == 7);
         la_tvalid   = (k >= 3) && (la_idx < 2);
         la_tdata    = 32'hD000_0000 + 32'(la_idx);
         la_tlast    = (la_idx == 1);
         la_hpri_req = (k >= 3) && (la_idx == 0);
         @(negedge clk);
         if (k >= 1 && k <= 8) begin
            chk("t3_up_tid",  32'(m_tid), 32'(0));
            chk("t3_up_data", m_tdata, 32'hC000_0000 + 32'(k - 1));
            chk("t3_la_held", 32'(la_tready), 32'(0));
         end else if (k == 9 || k == 10) begin
            chk("t3_la_tid",  32'(m_tid), 32'(1));
            chk("t3_la_data", m_tdata, 32'hD000_0000 + 32'(k - 9));
            chk("t3_cnt",     32'(hpri_gnt_cnt), 32'(1));
         end else if (k == 11) begin
            chk("t3_cnt_end", 32'(hpri_gnt_cnt), 32'(1));
         end
         up_fire = up_tvalid && up_tready;
         la_fire = la_tvalid && la_tready;
         next_cycle();
         if (up_fire) up_idx++;
         if (la_fire) la_idx++;
      end
      la_hpri_req = 1'b0;

      // ---- 4: LA idle-timeout release hands the port to waiting UP ----
      do_reset();
      for (int k = 0; k < 19; k++) begin
         la_tvalid = (k <= 1);
         la_tlast  = 1'b0;
         la_tdata  = 32'hE000_0000;
         up_tvalid = (k >= 2);
         up_tdata  = 32'hF000_0001;
         up_tlast  = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            chk("t4_la_tid", 32'(m_tid), 32'(1));
            chk("t4_la_vld", 32'(m_tvalid), 32'(1));
         end else if (k >= 2 && k <= 17) begin
            chk("t4_idle_rel", 32'(la_idle_rel), 32'(k == 17));
            chk("t4_up_wait",  32'(up_tready), 32'(0));
         end else if (k == 18) begin
            chk("t4_up_tid",    32'(m_tid), 32'(0));
            chk("t4_up_vld",    32'(m_tvalid), 32'(1));
            chk("t4_up_data",   m_tdata, 32'hF000_0001);
            chk("t4_rel_clear", 32'(la_idle_rel), 32'(0));
         end
         next_cycle();
      end

      // ---- 5: arb_enable gating ----
      do_reset();
      arb_enable = 1'b0;
      up_tvalid = 1'b1; up_tdata = 32'h0000_5A5A; up_tlast = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_no_grant", 32'(up_tready), 32'(0));
         next_cycle();
      end
      arb_enable = 1'b1;
      next_cycle();
      arb_enable = 1'b0;
      @(negedge clk);
      chk("t5_grant", 32'(up_tready), 32'(1));
      next_cycle();
      up_tlast = 1'b1;
      @(negedge clk);
      chk("t5_finish_pkt", 32'(m_tvalid), 32'(1));
      next_cycle();
      @(negedge clk);
      chk("t5_idle_after", 32'(up_tready), 32'(0));
      arb_enable = 1'b1;
      next_cycle();

      // ---- 6: random m_tready, both sources, scoreboard ----
      do_reset();
      up_idx = 0; la_idx = 0; exp_up = 0; exp_la = 0; pkt_open = 1'b0; cur_tid = 1'b0;
      up_tvalid = 1'b1; la_tvalid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         up_tdata = 32'hA500_0000 + 32'(up_idx); up_tlast = (up_idx % 3 == 2);
         la_tdata = 32'hB600_0000 + 32'(la_idx); la_tlast = (la_idx % 2 == 1);
         m_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            if (pkt_open) chk("t6_atomic", 32'(m_tid), 32'(cur_tid));
            if (m_tid == 1'b0) begin
               chk("t6_up_data", m_tdata, 32'hA500_0000 + 32'(exp_up));
               chk("t6_up_last", 32'(m_tlast), 32'(exp_up % 3 == 2));
               exp_up++;
            end else begin
               chk("t6_la_data", m_tdata, 32'hB600_0000 + 32'(exp_la));
               chk("t6_la_last", 32'(m_tlast), 32'(exp_la % 2 == 1));
               exp_la++;
            end
            pkt_open = !m_tlast;
            cur_tid  = m_tid;
         end
         up_fire = up_tvalid && up_tready;
         la_fire = la_tvalid && la_tready;
         next_cycle();
         if (up_fire) up_idx++;
         if (la_fire) la_idx++;
      end
      chk("t6_up_count", 32'(up_idx), 32'(exp_up));
      chk("t6_la_count", 32'(la_idx), 32'(exp_la));
      chk("t6_up_progress", 32'(exp_up > 20), 32'(1));
      chk("t6_la_progress", 32'(exp_la > 20), 32'(1));
      m_tready = 1'b1;

      // ---- 7: reset asserted mid UP packet ----
      do_reset();
      up_tvalid = 1'b1; up_tlast = 1'b0; up_tdata = 32'h7777_0001;
      next_cycle();
      @(negedge clk);
      chk("t7_mid_valid", 32'(m_tvalid), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_async_valid",  32'(m_tvalid), 32'(0));
      chk("t7_async_tready", 32'(up_tready), 32'(0));
      chk("t7_async_data",   m_tdata, 32'(0));
      next_cycle();
      la_tvalid = 1'b1; la_tdata = 32'h8888_0001; la_tlast = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t7_post_idle", 32'(m_tvalid), 32'(0));
      next_cycle();
      @(negedge clk);
      chk("t7_first_tid",  32'(m_tid), 32'(0));
      chk("t7_first_data", m_tdata, 32'h7777_0001);
      chk("t7_la_wait",    32'(la_tready), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
